// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch geometry, NOP encoding and fetch FSM states.
package cpu_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int MEM_DEPTH   = 32;
    localparam int RESET_PC    = 0;
    localparam int COUNT_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        S_RUN,
        S_FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// PC and fetch control: drives the instruction memory address, tags returned
// words with their PC, and handles stall, redirect and out-of-range fetches.
module fetch_unit #(
    parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int RESET_PC    = cpu_pkg::RESET_PC,
    parameter int MEM_DEPTH   = cpu_pkg::MEM_DEPTH,
    parameter int COUNT_WIDTH = cpu_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_target_i,
    input  logic [31:0]            instruction_i,
    output logic [PC_WIDTH-1:0]    pc_address_o,
    output logic [31:0]            instr_o,
    output logic [PC_WIDTH-1:0]    instr_pc_o,
    output logic                   instr_valid_o,
    output logic                   fetch_fault_o,
    output logic [COUNT_WIDTH-1:0] fetch_count_o
);
    import cpu_pkg::*;

    localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] LAST_PC  = PC_WIDTH'(MEM_DEPTH - 1);

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    tag_q, tag_d;
    logic                   valid_q, valid_d;
    fetch_state_t           state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   in_range;

    // A stall replays the presented address so memory returns the same word.
    assign pc_address_o = (stall_i & ~redirect_i & (state_q == S_RUN))
                        ? tag_q : pc_q;
    assign in_range     = (pc_address_o <= LAST_PC);

    assign instr_o       = instruction_i;
    assign instr_pc_o    = tag_q;
    assign instr_valid_o = valid_q;
    assign fetch_fault_o = (state_q == S_FAULT);
    assign fetch_count_o = count_q;

    always_comb begin
        pc_d    = pc_q;
        tag_d   = tag_q;
        valid_d = 1'b0;
        state_d = state_q;
        count_d = count_q;
        if (valid_q & ~stall_i & ~redirect_i) begin
            count_d = count_q + 1'b1;
        end
        unique case (state_q)
            S_RUN: begin
                tag_d   = pc_address_o;
                valid_d = ~redirect_i & in_range;
                // Freeze on the faulting address so it stays visible.
                if (!in_range) begin
                    state_d = S_FAULT;
                    pc_d    = pc_address_o;
                end else if (redirect_i) begin
                    pc_d = redirect_target_i;
                end else if (!stall_i) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            S_FAULT: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= START_PC;
            tag_q   <= START_PC;
            valid_q <= 1'b0;
            state_q <= S_RUN;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a 32-word registered instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] instruction_i;
    logic [31:0] pc_address_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        fetch_fault_o;
    logic [31:0] fetch_count_o;

    logic [31:0] mem [32];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .instruction_i     (instruction_i),
        .pc_address_o      (pc_address_o),
        .instr_o           (instr_o),
        .instr_pc_o        (instr_pc_o),
        .instr_valid_o     (instr_valid_o),
        .fetch_fault_o     (fetch_fault_o),
        .fetch_count_o     (fetch_count_o)
    );

    always @(posedge clk) begin
        if (rst) instruction_i <= 32'h0;
        else if (pc_address_o < 32) instruction_i <= mem[pc_address_o[4:0]];
        else instruction_i <= 32'h0;
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA5A5_0000 + pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every instruction accepted by decode must match the queue head.
    always @(negedge clk) begin
        if (instr_valid_o && !stall_i && !redirect_i && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc %0h expected none", instr_pc_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", instr_pc_o, e);
                chk("sb_instr", instr_o, word_at(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = word_at(32'(i));
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_target_i = 32'h0;
        tick();
        tick();
        chk("rst_valid", 32'(instr_valid_o), 32'h0);
        chk("rst_count", fetch_count_o, 32'h0);
        chk("rst_fault", 32'(fetch_fault_o), 32'h0);
        chk("rst_addr", pc_address_o, 32'h0);

        // Straight-line fetch
        for (int p = 0; p <= 4; p++) exp_q.push_back(32'(p));
        rst = 1'b0;
        tick();
        chk("first_pc", instr_pc_o, 32'h0);
        chk("first_valid", 32'(instr_valid_o), 32'h1);
        chk("first_addr", pc_address_o, 32'h1);
        chk("first_count", fetch_count_o, 32'h0);
        tick();
        tick();
        chk("run_addr", pc_address_o, 32'h3);
        chk("run_count", fetch_count_o, 32'h2);
        tick();
        chk("pre_stall_pc", instr_pc_o, 32'h3);

        // Stall two cycles on pc 3
        stall_i = 1'b1;
        #1;
        chk("stall_addr", pc_address_o, 32'h3);
        tick();
        chk("stall_pc", instr_pc_o, 32'h3);
        chk("stall_valid", 32'(instr_valid_o), 32'h1);
        chk("stall_count", fetch_count_o, 32'h3);
        tick();
        chk("stall_count2", fetch_count_o, 32'h3);
        stall_i = 1'b0;
        tick();
        chk("unstall_addr", pc_address_o, 32'h5);
        chk("unstall_pc", instr_pc_o, 32'h4);
        chk("unstall_count", fetch_count_o, 32'h4);

        // Redirect to 8 while pc 5 presented
        exp_q.push_back(32'h8);
        tick();
        chk("pre_redir_pc", instr_pc_o, 32'h5);
        redirect_i = 1'b1;
        redirect_target_i = 32'h8;
        tick();
        redirect_i = 1'b0;
        chk("redir_bubble", 32'(instr_valid_o), 32'h0);
        chk("redir_count", fetch_count_o, 32'h5);
        chk("redir_addr", pc_address_o, 32'h8);
        tick();
        chk("redir_pc", instr_pc_o, 32'h8);
        chk("redir_valid", 32'(instr_valid_o), 32'h1);

        // Stall and redirect together: redirect wins
        exp_q.push_back(32'h2);
        for (int p = 3; p <= 31; p++) exp_q.push_back(32'(p));
        tick();
        chk("sr_pre_pc", instr_pc_o, 32'h9);
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_target_i = 32'h2;
        #1;
        chk("sr_addr", pc_address_o, 32'hA);
        tick();
        stall_i = 1'b0;
        redirect_i = 1'b0;
        chk("sr_bubble", 32'(instr_valid_o), 32'h0);
        chk("sr_count", fetch_count_o, 32'h6);
        tick();
        chk("sr_pc", instr_pc_o, 32'h2);
        chk("sr_valid", 32'(instr_valid_o), 32'h1);

        // Run off the end of memory
        repeat (29) tick();
        chk("last_pc", instr_pc_o, 32'd31);
        chk("last_valid", 32'(instr_valid_o), 32'h1);
        chk("last_addr", pc_address_o, 32'd32);
        tick();
        chk("fault_set", 32'(fetch_fault_o), 32'h1);
        chk("fault_valid", 32'(instr_valid_o), 32'h0);
        chk("fault_addr", pc_address_o, 32'd32);
        chk("fault_count", fetch_count_o, 32'd36);
        redirect_i = 1'b1;
        redirect_target_i = 32'h0;
        tick();
        redirect_i = 1'b0;
        chk("fault_hold", 32'(fetch_fault_o), 32'h1);
        chk("fault_hold_valid", 32'(instr_valid_o), 32'h0);
        chk("fault_hold_addr", pc_address_o, 32'd32);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("clr_fault", 32'(fetch_fault_o), 32'h0);
        chk("clr_addr", pc_address_o, 32'h0);
        chk("clr_count", fetch_count_o, 32'h0);

        // Reset with stall and redirect pending
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        tick();
        tick();
        chk("r2_pc", instr_pc_o, 32'h1);
        chk("r2_count", fetch_count_o, 32'h1);
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_target_i = 32'd20;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        #1;
        chk("mid_rst_addr", pc_address_o, 32'h0);
        chk("mid_rst_valid", 32'(instr_valid_o), 32'h0);
        chk("mid_rst_count", fetch_count_o, 32'h0);
        tick();
        chk("mid_rst_pc", instr_pc_o, 32'h0);
        tick();

        // Redirect to an out-of-range target
        redirect_i = 1'b1;
        redirect_target_i = 32'd40;
        tick();
        redirect_i = 1'b0;
        chk("oor_addr", pc_address_o, 32'd40);
        chk("oor_nofault", 32'(fetch_fault_o), 32'h0);
        tick();
        chk("oor_fault", 32'(fetch_fault_o), 32'h1);
        chk("oor_valid", 32'(instr_valid_o), 32'h0);
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
